fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: loads the PC from the reset vector, then fetches
// opcode plus operand bytes over a stallable read bus and presents whole instructions.
module fetch_sequencer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned MAX_OPERANDS = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFC,
    localparam int unsigned VEC_BYTES = (ADDR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH,
    localparam int unsigned CNT_W     = $clog2(MAX_OPERANDS + 1)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               rdy,
    input  logic [DATA_WIDTH-1:0]              din,
    input  logic [CNT_W-1:0]                   opnd_cnt,
    input  logic                               redirect,
    input  logic [ADDR_WIDTH-1:0]              redirect_addr,
    input  logic                               instr_ready,
    output logic [ADDR_WIDTH-1:0]              addr,
    output logic                               r_w_n,
    output logic                               sync,
    output logic [ADDR_WIDTH-1:0]              pc,
    output logic                               instr_valid,
    output logic [DATA_WIDTH-1:0]              opcode,
    output logic [MAX_OPERANDS*DATA_WIDTH-1:0] operand,
    output logic [CNT_W-1:0]                   opnd_count
);

    localparam int unsigned VIDX_W = (VEC_BYTES > 1) ? $clog2(VEC_BYTES) : 1;
    localparam int unsigned EXT_W  = VEC_BYTES * DATA_WIDTH;
    localparam int unsigned OPND_W = MAX_OPERANDS * DATA_WIDTH;

    typedef enum logic [1:0] {VEC, FETCH_OP, FETCH_OPND, ISSUE} state_t;

    state_t             state;
    logic [VIDX_W-1:0]  vidx;
    logic [CNT_W-1:0]   oidx;
    logic [CNT_W-1:0]   cnt_sat;
    logic [EXT_W-1:0]   pc_ext;
    logic [ADDR_WIDTH-1:0] pc_vec;
    logic [OPND_W-1:0]  operand_ins;

    // Decoder operand count clamped to what the operand register can hold
    always_comb begin
        cnt_sat = (opnd_cnt > CNT_W'(MAX_OPERANDS)) ? CNT_W'(MAX_OPERANDS) : opnd_cnt;
    end

    // Byte-lane merge of din into the PC (vector load) and operand register
    always_comb begin
        pc_ext = EXT_W'(pc);
        for (int v = 0; v < int'(VEC_BYTES); v++) begin
            if (int'(vidx) == v) pc_ext[v*DATA_WIDTH +: DATA_WIDTH] = din;
        end
        pc_vec = pc_ext[ADDR_WIDTH-1:0];

        operand_ins = operand;
        for (int i = 0; i < int'(MAX_OPERANDS); i++) begin
            if (int'(oidx) == i) operand_ins[i*DATA_WIDTH +: DATA_WIDTH] = din;
        end
    end

    // Bus address and sync decode from current state
    always_comb begin
        addr = pc;
        sync = 1'b0;
        case (state)
            VEC:      addr = RESET_VECTOR + ADDR_WIDTH'(vidx);
            FETCH_OP: sync = 1'b1;
            default:  ;
        endcase
    end

    assign r_w_n = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= VEC;
            vidx        <= '0;
            oidx        <= '0;
            pc          <= '0;
            opcode      <= '0;
            operand     <= '0;
            opnd_count  <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                VEC: begin
                    if (rdy) begin
                        pc <= pc_vec;
                        if (vidx == VIDX_W'(VEC_BYTES - 1)) begin
                            vidx  <= '0;
                            state <= FETCH_OP;
                        end else begin
                            vidx <= vidx + VIDX_W'(1);
                        end
                    end
                end
                FETCH_OP: begin
                    if (redirect) begin
                        pc <= redirect_addr;
                    end else if (rdy) begin
                        opcode     <= din;
                        operand    <= '0;
                        opnd_count <= cnt_sat;
                        pc         <= pc + ADDR_WIDTH'(1);
                        oidx       <= '0;
                        if (cnt_sat == '0) begin
                            state       <= ISSUE;
                            instr_valid <= 1'b1;
                        end else begin
                            state <= FETCH_OPND;
                        end
                    end
                end
                FETCH_OPND: begin
                    if (redirect) begin
                        pc    <= redirect_addr;
                        state <= FETCH_OP;
                    end else if (rdy) begin
                        operand <= operand_ins;
                        pc      <= pc + ADDR_WIDTH'(1);
                        oidx    <= oidx + CNT_W'(1);
                        if (oidx == opnd_count - CNT_W'(1)) begin
                            state       <= ISSUE;
                            instr_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // A redirect alongside instr_ready still counts as consumption
                    if (redirect) begin
                        pc          <= redirect_addr;
                        state       <= FETCH_OP;
                        instr_valid <= 1'b0;
                    end else if (instr_ready) begin
                        state       <= FETCH_OP;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= VEC;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: memory model plus opcode-length table,
// expected instructions queued at stimulus time and compared when presented.
module tb_fetch_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned MO = 2;
    localparam int unsigned CW = 2;

    logic               clk;
    logic               reset_n;
    logic               rdy;
    logic [DW-1:0]      din;
    logic [CW-1:0]      opnd_cnt;
    logic               redirect;
    logic [AW-1:0]      redirect_addr;
    logic               instr_ready;
    logic [AW-1:0]      addr;
    logic               r_w_n;
    logic               sync;
    logic [AW-1:0]      pc;
    logic               instr_valid;
    logic [DW-1:0]      opcode;
    logic [MO*DW-1:0]   operand;
    logic [CW-1:0]      opnd_count;

    fetch_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OPERANDS(MO), .RESET_VECTOR(16'hFFFC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rdy(rdy), .din(din), .opnd_cnt(opnd_cnt),
        .redirect(redirect), .redirect_addr(redirect_addr), .instr_ready(instr_ready),
        .addr(addr), .r_w_n(r_w_n), .sync(sync), .pc(pc), .instr_valid(instr_valid),
        .opcode(opcode), .operand(operand), .opnd_count(opnd_count)
    );

    typedef struct packed {
        logic [DW-1:0]    op;
        logic [MO*DW-1:0] opnd;
        logic [CW-1:0]    cnt;
        logic [AW-1:0]    pc;
    } instr_t;

    logic [DW-1:0] mem [0:65535];
    logic [CW-1:0] opnd_tab [0:255];
    instr_t        sb[$];
    int            n_pass;
    int            n_total;

    assign din      = mem[addr];
    assign opnd_cnt = opnd_tab[din];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t mk(input logic [DW-1:0] op, input logic [MO*DW-1:0] opnd,
                                  input logic [CW-1:0] cnt, input logic [AW-1:0] p);
        instr_t r;
        r.op = op; r.opnd = opnd; r.cnt = cnt; r.pc = p;
        return r;
    endfunction

    function automatic instr_t seen();
        return {opcode, operand, opnd_count, pc};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = 0;
        while (instr_valid !== 1'b1 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rdy = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
        repeat (2) tick();
        n_total++;
        if ({addr, sync, r_w_n, instr_valid} !== {16'hFFFC, 1'b0, 1'b1, 1'b0})
            $display("FAIL reset_bus: got addr=%h sync=%b r_w_n=%b valid=%b expected FFFC 0 1 0",
                     addr, sync, r_w_n, instr_valid);
        else n_pass++;
        n_total++;
        if (seen() !== '0)
            $display("FAIL reset_regs: got %h expected 0", seen());
        else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_vector();
        n_total++;
        if (addr !== 16'hFFFC) $display("FAIL vec_lo: got %h expected FFFC", addr);
        else n_pass++;
        tick();
        n_total++;
        if ({addr, sync} !== {16'hFFFD, 1'b0}) $display("FAIL vec_hi: got %h/%b expected FFFD/0", addr, sync);
        else n_pass++;
        tick();
        n_total++;
        if ({addr, sync, pc} !== {16'h8000, 1'b1, 16'h8000})
            $display("FAIL vec_first_fetch: got %h/%b/%h expected 8000/1/8000", addr, sync, pc);
        else n_pass++;
    endtask

    task automatic test_three_byte();
        int lat;
        instr_t e;
        sb.push_back(mk(8'hAD, 16'h1234, 2'd2, 16'h8003));
        wait_valid(20, lat);
        n_total++;
        if (lat !== 3) $display("FAIL three_byte_latency: got %0d expected 3", lat);
        else n_pass++;
        n_total++;
        if (sb.size() == 0) $display("FAIL three_byte: got empty scoreboard expected entry");
        else begin
            e = sb.pop_front();
            if (seen() !== e) $display("FAIL three_byte: got %h expected %h", seen(), e);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        instr_t hold;
        hold = mk(8'hAD, 16'h1234, 2'd2, 16'h8003);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if ({instr_valid, seen(), addr} !== {1'b1, hold, 16'h8003})
                $display("FAIL backpressure_hold%0d: got %b/%h/%h expected 1/%h/8003",
                         k, instr_valid, seen(), addr, hold);
            else n_pass++;
        end
        instr_ready = 1'b1;
        tick();
        n_total++;
        if ({sync, addr, instr_valid} !== {1'b1, 16'h8003, 1'b0})
            $display("FAIL backpressure_release: got %b/%h/%b expected 1/8003/0", sync, addr, instr_valid);
        else n_pass++;
    endtask

    task automatic test_no_operand();
        int lat;
        instr_t e;
        sb.push_back(mk(8'hEA, 16'h0000, 2'd0, 16'h8004));
        wait_valid(20, lat);
        n_total++;
        if (lat !== 1) $display("FAIL no_operand_latency: got %0d expected 1", lat);
        else n_pass++;
        n_total++;
        if (sb.size() == 0) $display("FAIL no_operand: got empty scoreboard expected entry");
        else begin
            e = sb.pop_front();
            if (seen() !== e) $display("FAIL no_operand: got %h expected %h", seen(), e);
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        int lat;
        instr_t e;
        tick();
        tick();
        n_total++;
        if ({addr, sync} !== {16'h8005, 1'b0}) $display("FAIL redirect_pre: got %h/%b expected 8005/0", addr, sync);
        else n_pass++;
        redirect = 1'b1; redirect_addr = 16'h0200;
        tick();
        redirect = 1'b0;
        n_total++;
        if ({addr, sync, instr_valid} !== {16'h0200, 1'b1, 1'b0})
            $display("FAIL redirect_target: got %h/%b/%b expected 0200/1/0", addr, sync, instr_valid);
        else n_pass++;
        sb.push_back(mk(8'hEA, 16'h0000, 2'd0, 16'h0201));
        wait_valid(20, lat);
        n_total++;
        if (lat !== 1) $display("FAIL redirect_latency: got %0d expected 1", lat);
        else n_pass++;
        n_total++;
        if (sb.size() == 0) $display("FAIL redirect_instr: got empty scoreboard expected entry");
        else begin
            e = sb.pop_front();
            if (seen() !== e) $display("FAIL redirect_instr: got %h expected %h", seen(), e);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        int lat;
        int w;
        instr_t e;
        redirect = 1'b1; redirect_addr = 16'h8000;
        tick();
        redirect = 1'b0;
        n_total++;
        if ({addr, sync} !== {16'h8000, 1'b1}) $display("FAIL stall_restart: got %h/%b expected 8000/1", addr, sync);
        else n_pass++;
        sb.push_back(mk(8'hAD, 16'h1234, 2'd2, 16'h8003));
        tick();
        lat = 1;
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            lat++;
            n_total++;
            if ({addr, instr_valid} !== {16'h8001, 1'b0})
                $display("FAIL stall_hold%0d: got %h/%b expected 8001/0", k, addr, instr_valid);
            else n_pass++;
        end
        rdy = 1'b1;
        wait_valid(20, w);
        lat += w;
        n_total++;
        if (lat !== 3 + 3) $display("FAIL stall_latency: got %0d expected 6", lat);
        else n_pass++;
        n_total++;
        if (sb.size() == 0) $display("FAIL stall_instr: got empty scoreboard expected entry");
        else begin
            e = sb.pop_front();
            if (seen() !== e) $display("FAIL stall_instr: got %h expected %h", seen(), e);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        int lat;
        instr_t e;
        redirect = 1'b1; redirect_addr = 16'hFFFF;
        tick();
        redirect = 1'b0;
        n_total++;
        if ({addr, sync} !== {16'hFFFF, 1'b1}) $display("FAIL wrap_fetch: got %h/%b expected FFFF/1", addr, sync);
        else n_pass++;
        sb.push_back(mk(8'hB9, 16'h2211, 2'd2, 16'h0002));
        tick();
        n_total++;
        if ({addr, sync} !== {16'h0000, 1'b0}) $display("FAIL wrap_addr: got %h/%b expected 0000/0", addr, sync);
        else n_pass++;
        wait_valid(20, lat);
        n_total++;
        if (lat !== 2) $display("FAIL wrap_latency: got %0d expected 2", lat);
        else n_pass++;
        n_total++;
        if (sb.size() == 0) $display("FAIL wrap_instr: got empty scoreboard expected entry");
        else begin
            e = sb.pop_front();
            if (seen() !== e) $display("FAIL wrap_instr: got %h expected %h", seen(), e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        tick();
        tick();
        n_total++;
        if ({addr, sync} !== {16'h0003, 1'b0}) $display("FAIL mid_pre: got %h/%b expected 0003/0", addr, sync);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_total++;
        if ({addr, sync, instr_valid, pc} !== {16'hFFFC, 1'b0, 1'b0, 16'h0000})
            $display("FAIL mid_reset: got %h/%b/%b/%h expected FFFC/0/0/0000", addr, sync, instr_valid, pc);
        else n_pass++;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        n_total++;
        if ({addr, sync} !== {16'h8000, 1'b1}) $display("FAIL mid_restart: got %h/%b expected 8000/1", addr, sync);
        else n_pass++;
        rdy = 1'b0;
        tick();
        n_total++;
        if ({addr, sync, instr_valid} !== {16'h8000, 1'b1, 1'b0})
            $display("FAIL sync_stalled: got %h/%b/%b expected 8000/1/0", addr, sync, instr_valid);
        else n_pass++;
        rdy = 1'b1;
        n_total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        for (int o = 0; o < 256; o++) opnd_tab[o] = 2'd0;
        opnd_tab[8'hAD] = 2'd2;
        opnd_tab[8'h20] = 2'd2;
        opnd_tab[8'hB9] = 2'd3;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
        mem[16'h8003] = 8'hEA;
        mem[16'h8004] = 8'h20; mem[16'h8005] = 8'h55; mem[16'h8006] = 8'h66;
        mem[16'h0200] = 8'hEA;
        mem[16'hFFFF] = 8'hB9; mem[16'h0000] = 8'h11; mem[16'h0001] = 8'h22;
        mem[16'h0002] = 8'h20; mem[16'h0003] = 8'h77; mem[16'h0004] = 8'h88;

        test_reset();
        test_vector();
        test_three_byte();
        test_backpressure();
        test_no_operand();
        test_redirect();
        test_stall();
        test_wrap();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
